// File: rtl/apb_cmd_sequencer_if.sv
// rtl/apb_cmd_sequencer_if.sv - producer, master/slave-top and response signals of the command sequencer
interface apb_cmd_sequencer_if #(
   parameter int DEPTH = 4
) ();
   localparam int CW = $clog2(DEPTH + 1);

   logic          cmd_valid_i;
   logic [1:0]    cmd_i;
   logic          cmd_ready_o;
   logic [1:0]    add_o;
   logic          ready_i;
   logic [31:0]   rdata_i;
   logic          rsp_valid_o;
   logic [31:0]   rsp_data_o;
   logic          rsp_err_o;
   logic          rsp_ready_i;
   logic          busy_o;
   logic [CW-1:0] count_o;

   modport master (
      output cmd_valid_i, cmd_i, ready_i, rdata_i, rsp_ready_i,
      input  cmd_ready_o, add_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o, count_o
   );

   modport slave (
      input  cmd_valid_i, cmd_i, ready_i, rdata_i, rsp_ready_i,
      output cmd_ready_o, add_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o, count_o
   );
endinterface

// File: rtl/apb_cmd_sequencer.sv
// rtl/apb_cmd_sequencer.sv - command FIFO feeding one APB add transaction at a time, with timeout watchdog
module apb_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input logic               pclk,
   input logic               preset_n,
   apb_cmd_sequencer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETUP, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [1:0]    mem_q [DEPTH];
   logic [1:0]    mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    add_q, add_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic          rsp_err_q, rsp_err_d;

   logic full;
   logic push;
   logic pop;

   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      timer_d     = timer_q;
      add_d       = add_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;

      full = (count_q == CW'(DEPTH));
      // No-ops are handshaken like real commands but never stored.
      push = bus.cmd_valid_i && !full && (bus.cmd_i != 2'b00);
      pop  = (state_q == S_IDLE) && (count_q != '0);

      if (push) begin
         mem_d[wr_ptr_q] = bus.cmd_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               add_d   = mem_q[rd_ptr_q];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            add_d   = 2'b00;
            state_d = S_SETUP;
         end
         S_SETUP: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.ready_i) begin
               rsp_data_d  = bus.rdata_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               rsp_data_d  = 32'h0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q     <= S_IDLE;
         mem_q       <= '{default: 2'b00};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         timer_q     <= '0;
         add_q       <= 2'b00;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         timer_q     <= timer_d;
         add_q       <= add_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.cmd_ready_o = !full;
   assign bus.add_o       = add_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_data_o  = rsp_data_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign bus.busy_o      = (state_q != S_IDLE);
   assign bus.count_o     = count_q;
endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb/tb_apb_cmd_sequencer.sv - randomized and directed bench for apb_cmd_sequencer against a transaction-phase model
module tb_apb_cmd_sequencer;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic pclk;
   logic preset_n;

   apb_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

   apb_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .bus      (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int errors = 0;
   int checks = 0;

   // Model: queued commands, plus the in-flight transaction as a phase count.
   logic [1:0]  fq[$];
   bit          m_busy;
   bit          m_resp;
   int          m_phase;
   int          m_waits;
   logic [1:0]  m_cmd;
   logic [31:0] m_data;
   bit          m_err;
   int          exp_rsp = 0;
   int          got_rsp = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      m_busy  = 0;
      m_resp  = 0;
      m_phase = 0;
      m_waits = 0;
      m_cmd   = 2'b00;
      m_data  = 32'h0;
      m_err   = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"},     32'(bus.count_o),     32'd0);
      check({tag, "_cmd_ready"}, 32'(bus.cmd_ready_o), 32'd1);
      check({tag, "_add"},       32'(bus.add_o),       32'd0);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
      check({tag, "_rsp_data"},  bus.rsp_data_o,       32'd0);
      check({tag, "_rsp_err"},   32'(bus.rsp_err_o),   32'd0);
      check({tag, "_busy"},      32'(bus.busy_o),      32'd0);
   endtask

   task automatic compare_outputs();
      check("count",     32'(bus.count_o),     32'(fq.size()));
      check("cmd_ready", 32'(bus.cmd_ready_o), 32'(fq.size() < DEPTH));
      check("add",       32'(bus.add_o),       (m_busy && m_phase == 1) ? 32'(m_cmd) : 32'd0);
      check("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_resp));
      check("busy",      32'(bus.busy_o),      32'(m_busy));
      if (m_resp) begin
         check("rsp_data", bus.rsp_data_o,     m_data);
         check("rsp_err",  32'(bus.rsp_err_o), 32'(m_err));
      end
      if (bus.rsp_valid_o && bus.rsp_ready_i) got_rsp++;
   endtask

   // Phase 1 = command on the bus, 2 = setup, 3 = waiting for ready.
   task automatic model_edge();
      int         sz;
      bit         acc;
      logic [1:0] c;
      sz  = fq.size();
      c   = bus.cmd_i;
      acc = bus.cmd_valid_i && (sz < DEPTH) && (c != 2'b00);
      if (!m_busy) begin
         if (sz > 0) begin
            m_cmd   = fq.pop_front();
            m_busy  = 1;
            m_phase = 1;
         end
      end else if (m_resp) begin
         if (bus.rsp_ready_i) begin
            m_resp = 0;
            m_busy = 0;
            exp_rsp++;
         end
      end else if (m_phase < 3) begin
         m_phase++;
         m_waits = 0;
      end else begin
         m_waits++;
         if (bus.ready_i) begin
            m_resp = 1;
            m_data = bus.rdata_i;
            m_err  = 0;
         end else if (m_waits == TIMEOUT) begin
            m_resp = 1;
            m_data = 32'h0;
            m_err  = 1;
         end
      end
      if (acc) fq.push_back(c);
   endtask

   task automatic step();
      @(negedge pclk);
      compare_outputs();
      @(posedge pclk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit cv, input logic [1:0] c, input bit rdy,
                        input logic [31:0] rd, input bit rr);
      bus.cmd_valid_i = cv;
      bus.cmd_i       = c;
      bus.ready_i     = rdy;
      bus.rdata_i     = rd;
      bus.rsp_ready_i = rr;
   endtask

   logic [1:0] fill_seq [6] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
   logic [1:0] noop_seq [3] = '{2'b00, 2'b10, 2'b00};
   logic [1:0] rst_seq  [4] = '{2'b01, 2'b10, 2'b11, 2'b01};

   initial begin
      int p_cmd;
      int p_rdy;
      int p_rsp;

      drive(0, 2'b00, 0, 32'h0, 0);
      preset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge pclk);
      #1;
      check_reset_outputs("reset");
      preset_n = 1'b1;
      step();

      // Single command, then response held under backpressure with changing rdata.
      drive(1, 2'b01, 0, 32'h0, 0);
      step();
      drive(0, 2'b00, 1, 32'hDEAD_BEEF, 0);
      repeat (4) step();
      for (int i = 0; i < 10; i++) begin
         drive(0, 2'b00, 1'($urandom_range(0, 1)), $urandom, 0);
         step();
      end
      check("single_data", bus.rsp_data_o, 32'hDEAD_BEEF);
      drive(0, 2'b00, 0, 32'h0, 1);
      step();
      drive(0, 2'b00, 0, 32'h0, 0);
      repeat (2) step();

      // Fill to full with the response path stalled, then drain.
      for (int i = 0; i < 6; i++) begin
         drive(1, fill_seq[i], 1, 32'h1000 + 32'(i), 0);
         step();
      end
      drive(0, 2'b00, 1, 32'h2222, 0);
      check("full_count", 32'(bus.count_o), 32'd4);
      check("full_ready", 32'(bus.cmd_ready_o), 32'd0);
      repeat (3) step();
      for (int i = 0; i < 30; i++) begin
         drive(0, 2'b00, 1, 32'h3000 + 32'(i), 1);
         step();
      end

      // No-op filtering.
      for (int i = 0; i < 3; i++) begin
         drive(1, noop_seq[i], 1, 32'h4444, 1);
         step();
      end
      drive(0, 2'b00, 1, 32'h5555, 1);
      repeat (8) step();

      // Timeout on the first command; the second still issues afterwards.
      drive(1, 2'b11, 0, 32'h6666, 1);
      step();
      drive(1, 2'b01, 0, 32'h6666, 1);
      step();
      drive(0, 2'b00, 0, 32'h7777, 1);
      repeat (25) step();
      drive(0, 2'b00, 1, 32'h8888, 1);
      repeat (10) step();

      // Reset while waiting with three commands queued.
      for (int i = 0; i < 4; i++) begin
         drive(1, rst_seq[i], 0, 32'h9999, 0);
         step();
      end
      drive(0, 2'b00, 0, 32'h9999, 0);
      repeat (2) step();
      #3;
      preset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      @(posedge pclk);
      #1;
      preset_n = 1'b1;
      drive(0, 2'b00, 1, 32'hAAAA, 1);
      repeat (10) step();

      // Randomized traffic with varying pressure on every handshake.
      for (int blk = 0; blk < 10; blk++) begin
         p_cmd = $urandom_range(10, 90);
         p_rdy = (blk % 3 == 0) ? $urandom_range(0, 4) : $urandom_range(20, 100);
         p_rsp = $urandom_range(20, 100);
         for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 99) < p_cmd), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 99) < p_rdy), $urandom,
                  1'($urandom_range(0, 99) < p_rsp));
            step();
         end
      end

      drive(0, 2'b00, 1, 32'h0, 1);
      repeat (30) step();
      check("rsp_count", 32'(got_rsp), 32'(exp_rsp));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/apb_cmd_sequencer.md
Name: apb_cmd_sequencer

Overview:
Upstream command stage for the APB add master/slave pair. It buffers operation commands from a producer in a small FIFO and issues them one at a time on the 2-bit command input of the master/slave top. It then waits for the slave's ready, captures the returned read data, and presents one response per command on a valid/ready interface. A watchdog converts a transaction that never completes into an error response.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2
TIMEOUT, 16, max WAIT cycles without ready_i before error response; >= 2

Ports:
pclk  input  1  clock, all state on rising edge
preset_n  input  1  asynchronous active-low reset
cmd_valid_i  input  1  producer has a command
cmd_i  input  2  command code; 2'b00 = no-op, 01/10/11 = operations
cmd_ready_o  output  1  FIFO can accept (not full)
add_o  output  2  command to master (drives add_i of master/slave top)
ready_i  input  1  from ready_o of master/slave top
rdata_i  input  32  from rdata_o of master/slave top
rsp_valid_o  output  1  response available
rsp_data_o  output  32  captured read data (0 on error)
rsp_err_o  output  1  response is a timeout
rsp_ready_i  input  1  consumer accepts response
busy_o  output  1  state != IDLE
count_o  output  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async assert, sync release): FIFO empty, count_o=0, cmd_ready_o=1, add_o=2'b00, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, busy_o=0, state IDLE, timer=0.
- Reset mid-transaction discards the FIFO contents and any in-flight command. No response is produced for it.
- Push: cmd_valid_i && cmd_ready_o.
  - cmd_i==2'b00 is consumed and discarded (not queued, no response).
  - cmd_ready_o = (count_o != DEPTH). There is no bypass when full, even if a pop occurs in the same cycle.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, SETUP, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop head into cmd register and go to ISSUE next cycle.
  - ISSUE: add_o = cmd register for exactly this one cycle, then go to SETUP. add_o = 2'b00 in every other state.
  - SETUP: ready_i is ignored (APB setup phase). Clear timer and go to WAIT.
  - WAIT:
    - If ready_i=1: capture rdata_i into rsp_data_o, set rsp_err_o=0, go to RESP.
    - Else increment timer. When the timer reaches TIMEOUT-1 with ready_i still 0, set rsp_data_o=0, rsp_err_o=1, go to RESP.
  - RESP: rsp_valid_o=1. rsp_data_o and rsp_err_o are held stable until rsp_ready_i=1. On that handshake, rsp_valid_o drops next cycle and the FSM goes to IDLE.
- rsp_valid_o is registered and is 1 only in RESP.
- Back-to-back throughput: the next pop happens in the IDLE cycle after the response handshake. Minimum command-to-command spacing is 5 cycles (IDLE, ISSUE, SETUP, WAIT, RESP) when ready_i=1 and rsp_ready_i=1 immediately.
- Command latency: command accepted at edge N (FIFO previously empty, FSM IDLE) → add_o valid during cycle N+2, earliest rsp_valid_o at cycle N+5.
- The FIFO keeps accepting commands while a transaction is in flight.
- Ordering: responses are returned strictly in command order.

Test Plan:
- Single command: push cmd_i=2'b01; ready_i rises in the first WAIT cycle with rdata_i=32'hDEAD_BEEF → add_o=01 for exactly one cycle, then rsp_valid_o=1, rsp_data_o=DEADBEEF, rsp_err_o=0, held until rsp_ready_i.
- Fill/full: hold rsp_ready_i=0, push 6 commands (01,10,11,01,10,11) → first popped, FIFO reaches count_o=4 and cmd_ready_o=0. After responses drain, all 5 accepted commands appear on add_o in order 01,10,11,01,10, each as a one-cycle pulse.
- No-op filtering: push 00,10,00 → exactly one ISSUE (add_o=10), exactly one response, count_o never exceeds 1.
- Timeout: push 11 and hold ready_i=0 → after 16 WAIT cycles, rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0. The next queued command still issues afterwards.
- Backpressure: response pending with rsp_ready_i=0 for 10 cycles while rdata_i changes → rsp_data_o stays stable and add_o stays 00 until rsp_ready_i=1.
- Reset mid-op: assert preset_n=0 during WAIT with 3 commands queued → outputs immediately return to reset values, count_o=0, and no response is produced after release.
